// File: rtl/dcache_tag_dumper.sv
// DCache tag SRAM dumper: walks every set read-only and streams
// {set, way, coh, tag} per way entry over a valid/ready port.
module dcache_tag_dumper #(
  parameter int SETS         = 64,
  parameter int WAYS         = 4,
  parameter int TAG_BITS     = 22,
  parameter int SKIP_INVALID = 0,
  localparam int SET_BITS    = $clog2(SETS),
  localparam int WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int CNT_BITS    = $clog2(SETS * WAYS) + 1,
  localparam int ROW_BITS    = TAG_BITS * WAYS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [SET_BITS-1:0]   sram_addr,
  output logic                  sram_en,
  output logic                  sram_wmode,
  output logic [WAYS-1:0]       sram_wmask,
  output logic [ROW_BITS-1:0]   sram_wdata,
  input  logic [ROW_BITS-1:0]   sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SET_BITS-1:0]   out_set,
  output logic [WAY_BITS-1:0]   out_way,
  output logic [1:0]            out_coh,
  output logic [TAG_BITS-3:0]   out_tag,
  output logic [CNT_BITS-1:0]   entry_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    EMIT,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [SET_BITS-1:0]   set_q;
  logic [WAY_BITS-1:0]   way_q;
  logic [ROW_BITS-1:0]   line_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [TAG_BITS-1:0]   entry;
  logic                  skip;
  logic                  accept;
  logic                  hs;
  logic                  adv;
  logic                  last_way;
  logic                  last_set;

  assign entry    = line_q[int'(way_q) * TAG_BITS +: TAG_BITS];
  assign skip     = (SKIP_INVALID != 0) &&
                    (entry[TAG_BITS-1 -: 2] == 2'b00);
  assign last_way = (way_q == WAY_BITS'(WAYS - 1));
  assign last_set = (set_q == SET_BITS'(SETS - 1));

  // Write side is tied off so a dump can never disturb the array.
  assign sram_addr   = set_q;
  assign sram_wmode  = 1'b0;
  assign sram_wmask  = '0;
  assign sram_wdata  = '0;
  assign out_set     = set_q;
  assign out_way     = way_q;
  assign out_coh     = entry[TAG_BITS-1 -: 2];
  assign out_tag     = entry[TAG_BITS-3:0];
  assign entry_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    sram_en   = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    hs        = 1'b0;
    adv       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        busy    = 1'b1;
        sram_en = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        busy    = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = !skip;
        hs        = out_valid && out_ready;
        adv       = skip || hs;
        if (adv && last_way) begin
          state_d = last_set ? DONE : READ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        set_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == CAPTURE) begin
        line_q <= sram_rdata;
        way_q  <= '0;
      end
      if (hs) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (adv && !last_way) begin
        way_q <= way_q + 1'b1;
      end
      if (adv && last_way && !last_set) begin
        set_q <= set_q + 1'b1;
      end
    end
  end

endmodule
